seg_scan_ctrl: RTL

- Time-multiplexing scheduler for the Basys3 4-digit 7-segment display.
- Divides the system clock into digit slots and steps a 2-bit digit select through 0..3.
- Drives active-low anodes and cathodes for the current digit.
- Blanks all anodes at the start of each slot to prevent ghosting.
- Takes new display contents only at frame boundaries, so a frame never mixes old and new data.

---
 rtl/seg_scan_ctrl_pkg.sv | 26 ++
 rtl/seg_scan_ctrl_if.sv | 23 ++
 rtl/seg_scan_ctrl_hex_to_7seg.sv | 11 +
 rtl/seg_scan_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and types for the 4-digit seven-segment scan controller.
package seg_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Active-low {g,f,e,d,c,b,a}. Entry i sits at HEX_SEG[i], so 'F' is listed first.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  dig_en;
    logic        lz;
  } disp_t;

  localparam disp_t DISP_RST = '{data: 16'h0000, dp: 4'b0000, dig_en: 4'b1111, lz: 1'b0};

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display content in, scanned anode/cathode drive out.
interface seg_scan_ctrl_if;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  dig_en;
  logic        lz_supp;
  logic        load;
  logic        frame_done;
  logic [1:0]  sel;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;

  modport master (
    output data, dp, dig_en, lz_supp, load,
    input  frame_done, sel, an, seg, dp_n
  );

  modport slave (
    input  data, dp, dig_en, lz_supp, load,
    output frame_done, sel, an, seg, dp_n
  );
endinterface

// File: rtl/seg_scan_ctrl_hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_7seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan of four seven-segment digits with per-slot blanking
// and frame-aligned content update.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int DIV   = 100000,
  parameter int BLANK = 1000
) (
  input logic            clk,
  input logic            reset,
  seg_scan_ctrl_if.slave bus
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;
  logic [1:0]    sel;
  logic          wrap;
  logic          boundary;

  disp_t shadow;
  disp_t pending;
  disp_t in_disp;
  logic  pending_valid;

  logic [3:0] visible;
  logic       all_zero;
  logic [3:0] nibble;
  logic [6:0] seg_dec;

  logic [3:0] an_q;
  logic [6:0] seg_q;
  logic       dp_n_q;
  logic       frame_done_q;

  assign wrap     = (cnt == CW'(DIV - 1));
  assign boundary = wrap && (sel == 2'd3);

  assign in_disp = '{data: bus.data, dp: bus.dp, dig_en: bus.dig_en, lz: bus.lz_supp};

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      sel <= 2'd0;
    end else if (wrap) begin
      cnt <= '0;
      sel <= sel + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load on the boundary edge itself wins over anything already pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow        <= DISP_RST;
      pending       <= '0;
      pending_valid <= 1'b0;
    end else if (boundary) begin
      if (bus.load) begin
        shadow <= in_disp;
      end else if (pending_valid) begin
        shadow <= pending;
      end
      pending_valid <= 1'b0;
    end else if (bus.load) begin
      pending       <= in_disp;
      pending_valid <= 1'b1;
    end
  end

  // Walk from the leftmost digit down; a digit is suppressed while every
  // nibble from the left edge down to it is zero.
  always_comb begin
    all_zero = 1'b1;
    visible  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero   = all_zero && (shadow.data[4*k +: 4] == 4'h0);
      visible[k] = shadow.dig_en[k] && !(shadow.lz && (k != 0) && all_zero);
    end
  end

  assign nibble = shadow.data[{sel, 2'b00} +: 4];

  hex_to_7seg u_dec (
    .hex (nibble),
    .seg (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      an_q         <= AN_OFF;
      seg_q        <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= boundary;
      if (cnt < CW'(BLANK)) begin
        an_q   <= AN_OFF;
        seg_q  <= SEG_BLANK;
        dp_n_q <= 1'b1;
      end else begin
        seg_q <= seg_dec;
        if (visible[sel]) begin
          an_q   <= ~(4'b0001 << sel);
          dp_n_q <= ~shadow.dp[sel];
        end else begin
          an_q   <= AN_OFF;
          dp_n_q <= 1'b1;
        end
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sel        = sel;

endmodule
